term_screen: RTL and testbench

TERM_SCREEN -- requirements
Module: term_screen

---
 rtl/term_pkg.sv | 30 +++
 rtl/term_ram.sv | 21 ++
 rtl/term_screen.sv | 187 ++++++++++++++++++
 tb/tb_term_screen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/term_pkg.sv
// Shared constants for the terminal screen: FSM state codes, ASCII codes
// and the nibble-to-hex-character mapping.
package term_pkg;
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_REF_RD    = 4'd1;
  localparam logic [3:0] ST_REF_SEND  = 4'd2;
  localparam logic [3:0] ST_REF_WAIT  = 4'd3;
  localparam logic [3:0] ST_EOL_CR    = 4'd4;
  localparam logic [3:0] ST_EOL_LF    = 4'd5;
  localparam logic [3:0] ST_CUR_RD    = 4'd6;
  localparam logic [3:0] ST_CUR_SEND  = 4'd7;
  localparam logic [3:0] ST_CUR_WAIT  = 4'd8;
  localparam logic [3:0] ST_ECHO_SEND = 4'd9;
  localparam logic [3:0] ST_ECHO_WAIT = 4'd10;
  localparam logic [3:0] ST_HEX_WR    = 4'd11;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_H     = 8'h68;
  localparam logic [7:0] CH_J     = 8'h6A;
  localparam logic [7:0] CH_K     = 8'h6B;
  localparam logic [7:0] CH_L     = 8'h6C;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  // Lowercase hex digit for one nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction
endpackage

// File: rtl/term_ram.sv
// Single-port character buffer with registered (1-cycle) read, read-before-write.
module term_ram #(
  parameter int DEPTH = 960,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] INIT = WIDTH'(8'h20)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  // Contents survive reset; the initialiser only sets the power-up image.
  logic [WIDTH-1:0] mem [DEPTH] = '{default: INIT};

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/term_screen.sv
// Character-cell terminal: keyboard bytes move the cursor, write and echo cells,
// space retransmits the whole screen; a posted 32-bit value is rendered in hex.
module term_screen
  import term_pkg::*;
#(
  parameter int COLS     = 40,
  parameter int ROWS     = 24,
  parameter int HEX_ADDR = 155,
  localparam int AW      = $clog2(COLS*ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    i_byte,
  input  logic          i_byte_v,
  input  logic [31:0]   i_val,
  input  logic          i_val_v,
  input  logic          i_tx_done,
  output logic [7:0]    o_byte,
  output logic          o_byte_v,
  output logic          o_busy,
  output logic [AW-1:0] o_cursor
);
  localparam int N  = COLS*ROWS;
  localparam int CW = $clog2(COLS+1);
  localparam logic [AW-1:0] LAST   = AW'(N-1);
  localparam logic [AW-1:0] COLS_A = AW'(COLS);
  localparam logic [AW-1:0] LROW   = AW'(N-COLS);
  localparam logic [AW-1:0] HEX_A  = AW'(HEX_ADDR);
  localparam logic [CW-1:0] LCOL   = CW'(COLS-1);

  logic [3:0]    state;
  logic [AW-1:0] cursor, ref_idx;
  logic [CW-1:0] cur_col, ref_col;
  logic [2:0]    hex_idx;
  logic          pend_v;
  logic [31:0]   pend_val, hex_val;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata, ram_rdata;
  logic          printable, is_move;

  assign printable = (i_byte > CH_SP) && (i_byte <= CH_TILDE);
  assign is_move   = (i_byte == CH_H) || (i_byte == CH_J) ||
                     (i_byte == CH_K) || (i_byte == CH_L);
  assign o_busy    = (state != ST_IDLE);
  assign o_cursor  = cursor;

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = cursor;
    ram_wdata = i_byte;
    case (state)
      ST_IDLE:   ram_we = i_byte_v && printable && !is_move;
      ST_REF_RD: ram_addr = ref_idx;
      ST_HEX_WR: begin
        // Cell k takes nibble 7-k, so the most significant digit lands first.
        ram_we    = 1'b1;
        ram_addr  = HEX_A + AW'(hex_idx);
        ram_wdata = hex_char(hex_val[{~hex_idx, 2'b11} -: 4]);
      end
      default: ;
    endcase
  end

  term_ram #(.DEPTH(N), .WIDTH(8), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_REF_RD;
      ref_idx  <= '0;
      ref_col  <= '0;
      cursor   <= '0;
      cur_col  <= '0;
      hex_idx  <= '0;
      hex_val  <= '0;
      pend_v   <= 1'b0;
      pend_val <= '0;
      o_byte   <= '0;
      o_byte_v <= 1'b0;
    end else begin
      o_byte_v <= 1'b0;
      if (i_val_v) begin
        pend_v   <= 1'b1;
        pend_val <= i_val;
      end
      case (state)
        ST_IDLE: begin
          if (i_byte_v) begin
            if (i_byte == CH_SP) begin
              ref_idx <= '0;
              ref_col <= '0;
              state   <= ST_REF_RD;
            end else if (i_byte == CH_H) begin
              if (cur_col != '0) begin
                cursor  <= cursor - AW'(1);
                cur_col <= cur_col - CW'(1);
              end
              state <= ST_CUR_RD;
            end else if (i_byte == CH_L) begin
              if (cur_col != LCOL) begin
                cursor  <= cursor + AW'(1);
                cur_col <= cur_col + CW'(1);
              end
              state <= ST_CUR_RD;
            end else if (i_byte == CH_K) begin
              if (cursor >= COLS_A) cursor <= cursor - COLS_A;
              state <= ST_CUR_RD;
            end else if (i_byte == CH_J) begin
              if (cursor < LROW) cursor <= cursor + COLS_A;
              state <= ST_CUR_RD;
            end else if (printable) begin
              o_byte <= i_byte;
              state  <= ST_ECHO_SEND;
            end
          end else if (pend_v) begin
            // Snapshot the value; one arriving this cycle stays pending.
            hex_val <= pend_val;
            hex_idx <= '0;
            if (!i_val_v) pend_v <= 1'b0;
            state   <= ST_HEX_WR;
          end
        end
        ST_REF_RD:   state <= ST_REF_SEND;
        ST_REF_SEND: begin
          o_byte   <= ram_rdata;
          o_byte_v <= 1'b1;
          state    <= ST_REF_WAIT;
        end
        ST_REF_WAIT: if (i_tx_done) begin
          if (ref_col == LCOL) begin
            o_byte   <= CH_CR;
            o_byte_v <= 1'b1;
            state    <= ST_EOL_CR;
          end else begin
            ref_idx <= ref_idx + AW'(1);
            ref_col <= ref_col + CW'(1);
            state   <= ST_REF_RD;
          end
        end
        ST_EOL_CR: if (i_tx_done) begin
          o_byte   <= CH_LF;
          o_byte_v <= 1'b1;
          state    <= ST_EOL_LF;
        end
        ST_EOL_LF: if (i_tx_done) begin
          if (ref_idx == LAST) begin
            state <= ST_IDLE;
          end else begin
            ref_idx <= ref_idx + AW'(1);
            ref_col <= '0;
            state   <= ST_REF_RD;
          end
        end
        ST_CUR_RD:   state <= ST_CUR_SEND;
        ST_CUR_SEND: begin
          o_byte   <= ram_rdata;
          o_byte_v <= 1'b1;
          state    <= ST_CUR_WAIT;
        end
        ST_CUR_WAIT: if (i_tx_done) state <= ST_IDLE;
        ST_ECHO_SEND: begin
          o_byte_v <= 1'b1;
          if (cursor == LAST) begin
            cursor  <= '0;
            cur_col <= '0;
          end else begin
            cursor  <= cursor + AW'(1);
            cur_col <= (cur_col == LCOL) ? '0 : cur_col + CW'(1);
          end
          state <= ST_ECHO_WAIT;
        end
        ST_ECHO_WAIT: if (i_tx_done) state <= ST_IDLE;
        ST_HEX_WR: begin
          hex_idx <= hex_idx + 3'd1;
          if (hex_idx == 3'd7) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_term_screen.sv
// Randomised bench for term_screen: a screen/cursor model predicts every
// transmitted byte and the cursor after each keystroke.
module tb_term_screen;
  localparam int COLS = 40, ROWS = 24, N = COLS*ROWS, HEX = 155, AW = 10;

  logic          clk = 1'b0, rst = 1'b1;
  logic [7:0]    i_byte = '0;
  logic          i_byte_v = 1'b0;
  logic [31:0]   i_val = '0;
  logic          i_val_v = 1'b0, i_tx_done = 1'b0;
  logic [7:0]    o_byte;
  logic          o_byte_v, o_busy;
  logic [AW-1:0] o_cursor;

  always #5 clk = ~clk;

  term_screen #(.COLS(COLS), .ROWS(ROWS), .HEX_ADDR(HEX)) dut (
    .clk(clk), .rst(rst), .i_byte(i_byte), .i_byte_v(i_byte_v),
    .i_val(i_val), .i_val_v(i_val_v), .i_tx_done(i_tx_done),
    .o_byte(o_byte), .o_byte_v(o_byte_v), .o_busy(o_busy), .o_cursor(o_cursor)
  );

  int total = 0, bad = 0;
  logic [7:0]  mdl [N];
  int          mcur;
  bit          mpend;
  logic [31:0] mval;
  logic [7:0]  tx_q[$], exp_q[$], last_tx[$];
  int          dbl = 0, cnt = 0;
  bit          prev_v = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transmitter: capture each strobe, answer i_tx_done four cycles later.
  initial forever begin
    @(negedge clk);
    i_tx_done = 1'b0;
    if (rst) begin
      cnt = 0;
      prev_v = 1'b0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) i_tx_done = 1'b1;
      end
      if (o_byte_v) begin
        tx_q.push_back(o_byte);
        cnt = 4;
        if (prev_v) dbl++;
      end
      prev_v = o_byte_v;
    end
  end

  function automatic int pos(input int i);
    return i + 2*(i/COLS);
  endfunction

  task automatic exp_refresh();
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(mdl[i]);
      if (i % COLS == COLS-1) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end
    end
  endtask

  task automatic apply_hex();
    string s;
    if (mpend) begin
      s = $sformatf("%08h", mval);
      for (int k = 0; k < 8; k++) mdl[HEX+k] = s[k];
      mpend = 1'b0;
    end
  endtask

  task automatic model_key(input logic [7:0] b);
    if (b == 8'h20) exp_refresh();
    else if (b inside {8'h68, 8'h6C, 8'h6B, 8'h6A}) begin
      if (b == 8'h68 && mcur % COLS != 0)        mcur -= 1;
      if (b == 8'h6C && mcur % COLS != COLS-1)   mcur += 1;
      if (b == 8'h6B && mcur / COLS != 0)        mcur -= COLS;
      if (b == 8'h6A && mcur / COLS != ROWS-1)   mcur += COLS;
      exp_q.push_back(mdl[mcur]);
    end else if (b >= 8'h21 && b <= 8'h7E) begin
      mdl[mcur] = b;
      exp_q.push_back(b);
      mcur = (mcur + 1) % N;
    end
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    for (int c = 0; c < 20000 && quiet < 3; c++) begin
      @(negedge clk);
      quiet = o_busy ? 0 : quiet + 1;
    end
    if (quiet < 3) chk({tag, "_timeout_busy"}, 64'(o_busy), 64'd0);
  endtask

  task automatic cmp_tx(input string tag);
    int errs = 0;
    chk({tag, "_count"}, 64'(tx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < tx_q.size() && i < exp_q.size(); i++)
      if (tx_q[i] !== exp_q[i]) errs++;
    chk({tag, "_data"}, 64'(errs), 64'd0);
    last_tx = tx_q;
    tx_q.delete();
    exp_q.delete();
  endtask

  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    i_byte = b; i_byte_v = 1'b1;
    @(negedge clk);
    i_byte_v = 1'b0;
  endtask

  task automatic send(input string tag, input logic [7:0] b);
    drive_byte(b);
    wait_idle(tag);
    model_key(b);
    apply_hex();
    cmp_tx(tag);
    chk({tag, "_cursor"}, 64'(o_cursor), 64'(mcur));
  endtask

  task automatic pulse_val(input logic [31:0] v);
    @(negedge clk);
    i_val = v; i_val_v = 1'b1;
    @(negedge clk);
    i_val_v = 1'b0;
    mpend = 1'b1;
    mval = v;
  endtask

  function automatic logic [63:0] hex_text();
    logic [63:0] h = '0;
    for (int k = 0; k < 8; k++)
      h = {h[55:0], (last_tx.size() > pos(HEX+k)) ? last_tx[pos(HEX+k)] : 8'h00};
    return h;
  endfunction

  initial begin
    for (int i = 0; i < N; i++) mdl[i] = 8'h20;
    mcur = 0; mpend = 1'b0; mval = '0;

    // Reset values, then the automatic refresh.
    repeat (3) @(negedge clk);
    chk("rst_obyte", 64'(o_byte), 64'd0);
    chk("rst_obyte_v", 64'(o_byte_v), 64'd0);
    chk("rst_cursor", 64'(o_cursor), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("auto_refresh_busy", 64'(o_busy), 64'd1);
    wait_idle("boot");
    chk("boot_strobes", 64'(tx_q.size()), 64'd1008);
    exp_refresh();
    cmp_tx("boot");

    // Clamped moves at the top-left corner.
    send("h_clamp", 8'h68);
    send("k_clamp", 8'h6B);
    chk("clamp_cursor", 64'(o_cursor), 64'd0);
    send("j_down", 8'h6A);
    chk("j_cursor", 64'(o_cursor), 64'd40);

    // Walk to the last cell and type across the wrap.
    repeat (22) send("nav_j", 8'h6A);
    repeat (39) send("nav_l", 8'h6C);
    chk("at_last_cell", 64'(o_cursor), 64'd959);
    send("wrap_A", 8'h41);
    chk("wrap_cursor", 64'(o_cursor), 64'd0);

    // Hex rendering shown by a refresh.
    pulse_val(32'hB16B00B5);
    wait_idle("hex1");
    apply_hex();
    send("ref_hex1", 8'h20);
    chk("hex1_text", hex_text(), "b16b00b5");
    chk("cell959", 64'(last_tx[pos(959)]), 64'h41);

    // Values and a keystroke arriving mid-refresh.
    drive_byte(8'h20);
    repeat (20) @(negedge clk);
    i_val = 32'h1; i_val_v = 1'b1; @(negedge clk); i_val_v = 1'b0;
    repeat (30) @(negedge clk);
    pulse_val(32'h31337000);
    repeat (10) @(negedge clk);
    chk("busy_mid_refresh", 64'(o_busy), 64'd1);
    drive_byte(8'h6A);
    exp_refresh();
    wait_idle("ref_busy");
    apply_hex();
    cmp_tx("ref_busy");
    chk("dropped_j_cursor", 64'(o_cursor), 64'(mcur));
    send("ref_hex2", 8'h20);
    chk("hex2_text", hex_text(), "31337000");

    // Random keystrokes and values.
    for (int n = 0; n < 80; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'h68;
        1: b = 8'h6C;
        2: b = 8'h6B;
        3: b = 8'h6A;
        4, 5, 6: b = 8'($urandom_range(8'h21, 8'h7E));
        7: b = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 8'h1F)) : 8'($urandom_range(8'h7F, 8'hFF));
        default: b = 8'h00;
      endcase
      if (r >= 8) begin
        pulse_val($urandom);
        wait_idle("rnd_hex");
        apply_hex();
      end else send("rnd", b);
    end
    send("rnd_final_ref", 8'h20);

    // Reset in the middle of a refresh; a pending value is discarded.
    drive_byte(8'h20);
    repeat (40) @(negedge clk);
    i_val = 32'hDEADBEEF; i_val_v = 1'b1; @(negedge clk); i_val_v = 1'b0;
    for (int c = 0; c < 20000 && tx_q.size() < 525; c++) @(negedge clk);
    chk("reached_cell500", 64'(tx_q.size() >= 525), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_obyte_v", 64'(o_byte_v), 64'd0);
    chk("midrst_cursor", 64'(o_cursor), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tx_q.delete();
    mcur = 0;
    mpend = 1'b0;
    @(negedge clk);
    chk("restart_busy", 64'(o_busy), 64'd1);
    wait_idle("restart");
    exp_refresh();
    cmp_tx("restart");
    chk("single_cycle_strobes", 64'(dbl), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
